// File: rtl/rggen_register_access_initiator.sv
//------------------------------------------------------------------------------
// rggen_register_access_initiator: command -> register access -> response bridge.
// Optional access timeout enabled by macro RGGEN_ACCESS_TIMEOUT_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rggen_register_access_initiator #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [DATA_WIDTH-1:0]    i_cmd_write_data,
  input  logic [DATA_WIDTH-1:0]    i_cmd_write_mask,
  output logic                     o_access_valid,
  input  logic                     i_access_ready,
  output logic                     o_access_write,
  output logic [ADDRESS_WIDTH-1:0] o_access_address,
  output logic [DATA_WIDTH-1:0]    o_access_write_data,
  output logic [DATA_WIDTH-1:0]    o_access_mask,
  input  logic [DATA_WIDTH-1:0]    i_access_read_data,
  input  logic [1:0]               i_access_status,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_WIDTH-1:0]    o_rsp_read_data,
  output logic [1:0]               o_rsp_status
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef RGGEN_ACCESS_TIMEOUT_EN
  localparam int                  COUNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] timeout_count_q;
`endif

  state_e                   state_q;
  logic                     cmd_ready_q;
  logic                     access_valid_q;
  logic                     rsp_valid_q;
  logic                     access_write_q;
  logic [ADDRESS_WIDTH-1:0] access_address_q;
  logic [DATA_WIDTH-1:0]    access_write_data_q;
  logic [DATA_WIDTH-1:0]    access_mask_q;
  logic [DATA_WIDTH-1:0]    rsp_read_data_q;
  logic [1:0]               rsp_status_q;

  // Handshake flags are registered alongside the state so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= IDLE;
      cmd_ready_q         <= 1'b1;
      access_valid_q      <= 1'b0;
      rsp_valid_q         <= 1'b0;
      access_write_q      <= 1'b0;
      access_address_q    <= '0;
      access_write_data_q <= '0;
      access_mask_q       <= '0;
      rsp_read_data_q     <= '0;
      rsp_status_q        <= '0;
`ifdef RGGEN_ACCESS_TIMEOUT_EN
      timeout_count_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_cmd_valid) begin
            state_q             <= ACCESS;
            cmd_ready_q         <= 1'b0;
            access_valid_q      <= 1'b1;
            access_write_q      <= i_cmd_write;
            access_address_q    <= i_cmd_address;
            access_write_data_q <= i_cmd_write ? i_cmd_write_data : '0;
            access_mask_q       <= i_cmd_write ? i_cmd_write_mask : '1;
`ifdef RGGEN_ACCESS_TIMEOUT_EN
            timeout_count_q     <= '0;
`endif
          end
        end
        ACCESS: begin
          // A ready arriving on the final allowed cycle still completes normally.
          if (i_access_ready) begin
            state_q         <= RESPOND;
            access_valid_q  <= 1'b0;
            rsp_valid_q     <= 1'b1;
            rsp_read_data_q <= access_write_q ? '0 : i_access_read_data;
            rsp_status_q    <= i_access_status;
          end
`ifdef RGGEN_ACCESS_TIMEOUT_EN
          else if (timeout_count_q == COUNT_LAST) begin
            state_q         <= RESPOND;
            access_valid_q  <= 1'b0;
            rsp_valid_q     <= 1'b1;
            rsp_read_data_q <= '0;
            rsp_status_q    <= STATUS_TIMEOUT;
          end else begin
            timeout_count_q <= timeout_count_q + COUNT_ONE;
          end
`endif
        end
        RESPOND: begin
          if (i_rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q        <= IDLE;
          cmd_ready_q    <= 1'b1;
          access_valid_q <= 1'b0;
          rsp_valid_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_ready         = cmd_ready_q;
  assign o_access_valid      = access_valid_q;
  assign o_access_write      = access_write_q;
  assign o_access_address    = access_address_q;
  assign o_access_write_data = access_write_data_q;
  assign o_access_mask       = access_mask_q;
  assign o_rsp_valid         = rsp_valid_q;
  assign o_rsp_read_data     = rsp_read_data_q;
  assign o_rsp_status        = rsp_status_q;

endmodule

`default_nettype wire

// File: tb/tb_rggen_register_access_initiator.sv
//------------------------------------------------------------------------------
// tb_rggen_register_access_initiator: directed + randomized transactions checked
// against a transaction-level model (cycle counts derived from wait/hold). Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rggen_register_access_initiator;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

`ifdef RGGEN_ACCESS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_write;
  logic [AW-1:0] i_cmd_address;
  logic [DW-1:0] i_cmd_write_data;
  logic [DW-1:0] i_cmd_write_mask;
  logic          o_access_valid;
  logic          i_access_ready;
  logic          o_access_write;
  logic [AW-1:0] o_access_address;
  logic [DW-1:0] o_access_write_data;
  logic [DW-1:0] o_access_mask;
  logic [DW-1:0] i_access_read_data;
  logic [1:0]    i_access_status;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_read_data;
  logic [1:0]    o_rsp_status;

  int n_vec = 0;
  int n_err = 0;

  rggen_register_access_initiator #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_cmd_valid        (i_cmd_valid),
    .o_cmd_ready        (o_cmd_ready),
    .i_cmd_write        (i_cmd_write),
    .i_cmd_address      (i_cmd_address),
    .i_cmd_write_data   (i_cmd_write_data),
    .i_cmd_write_mask   (i_cmd_write_mask),
    .o_access_valid     (o_access_valid),
    .i_access_ready     (i_access_ready),
    .o_access_write     (o_access_write),
    .o_access_address   (o_access_address),
    .o_access_write_data(o_access_write_data),
    .o_access_mask      (o_access_mask),
    .i_access_read_data (i_access_read_data),
    .i_access_status    (i_access_status),
    .o_rsp_valid        (o_rsp_valid),
    .i_rsp_ready        (i_rsp_ready),
    .o_rsp_read_data    (o_rsp_read_data),
    .o_rsp_status       (o_rsp_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cmd();
    i_cmd_valid      = 1'($urandom);
    i_cmd_write      = 1'($urandom);
    i_cmd_address    = AW'($urandom);
    i_cmd_write_data = DW'($urandom);
    i_cmd_write_mask = DW'($urandom);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, 64'(o_cmd_ready), 64'(1));
    chk({tag, "_access_valid"}, 64'(o_access_valid), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'(0));
    chk({tag, "_access_write"}, 64'(o_access_write), 64'(0));
    chk({tag, "_access_address"}, 64'(o_access_address), 64'(0));
    chk({tag, "_access_wdata"}, 64'(o_access_write_data), 64'(0));
    chk({tag, "_access_mask"}, 64'(o_access_mask), 64'(0));
    chk({tag, "_rsp_data"}, 64'(o_rsp_read_data), 64'(0));
    chk({tag, "_rsp_status"}, 64'(o_rsp_status), 64'(0));
  endtask

  // One complete transaction. Entered and left one time unit after an edge with the DUT idle.
  // wt = cycles of access-ready low before it is raised; hold = cycles response is stalled.
  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] wm, input logic [DW-1:0] rd, input logic [1:0] st,
                        input int wt, input int hold);
    logic [DW-1:0] exp_wd, exp_m, exp_rd;
    logic [1:0]    exp_st;
    bit            timed_out;
    int            n_acc;
    exp_wd    = wr ? wd : '0;
    exp_m     = wr ? wm : '1;
    timed_out = TO_EN && (wt >= TO);
    n_acc     = timed_out ? TO : wt + 1;
    exp_rd    = (timed_out || wr) ? '0 : rd;
    exp_st    = timed_out ? 2'b11 : st;

    chk("idle_cmd_ready", 64'(o_cmd_ready), 64'(1));
    chk("idle_access_valid", 64'(o_access_valid), 64'(0));
    chk("idle_rsp_valid", 64'(o_rsp_valid), 64'(0));
    i_cmd_valid        = 1'b1;
    i_cmd_write        = wr;
    i_cmd_address      = addr;
    i_cmd_write_data   = wd;
    i_cmd_write_mask   = wm;
    i_access_ready     = 1'b0;
    i_access_read_data = DW'($urandom);
    i_access_status    = 2'($urandom);
    i_rsp_ready        = 1'($urandom);
    step();

    for (int k = 0; k < n_acc; k++) begin
      chk("acc_valid", 64'(o_access_valid), 64'(1));
      chk("acc_cmd_ready", 64'(o_cmd_ready), 64'(0));
      chk("acc_rsp_valid", 64'(o_rsp_valid), 64'(0));
      chk("acc_write", 64'(o_access_write), 64'(wr));
      chk("acc_address", 64'(o_access_address), 64'(addr));
      chk("acc_wdata", 64'(o_access_write_data), 64'(exp_wd));
      chk("acc_mask", 64'(o_access_mask), 64'(exp_m));
      scramble_cmd();
      i_access_ready     = (k == wt);
      i_access_read_data = (k == wt) ? rd : DW'($urandom);
      i_access_status    = (k == wt) ? st : 2'($urandom);
      i_rsp_ready        = 1'($urandom);
      step();
    end

    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", 64'(o_rsp_valid), 64'(1));
      chk("rsp_cmd_ready", 64'(o_cmd_ready), 64'(0));
      chk("rsp_access_valid", 64'(o_access_valid), 64'(0));
      chk("rsp_data", 64'(o_rsp_read_data), 64'(exp_rd));
      chk("rsp_status", 64'(o_rsp_status), 64'(exp_st));
      scramble_cmd();
      i_cmd_valid        = 1'b1;
      i_access_ready     = 1'($urandom);
      i_access_read_data = DW'($urandom);
      i_access_status    = 2'($urandom);
      i_rsp_ready        = (h == hold);
      step();
    end

    chk("ret_cmd_ready", 64'(o_cmd_ready), 64'(1));
    chk("ret_rsp_valid", 64'(o_rsp_valid), 64'(0));
    chk("ret_access_valid", 64'(o_access_valid), 64'(0));
    i_cmd_valid    = 1'b0;
    i_access_ready = 1'b0;
    i_rsp_ready    = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    i_cmd_valid        = 1'b0;
    i_cmd_write        = 1'b0;
    i_cmd_address      = '0;
    i_cmd_write_data   = '0;
    i_cmd_write_mask   = '0;
    i_access_ready     = 1'b0;
    i_access_read_data = '0;
    i_access_status    = '0;
    i_rsp_ready        = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_reset_state("reset");

    // Minimum-latency write, then read with wait states and error status.
    do_txn(1'b1, 16'h0010, 32'hA5A5_0000, 32'hFFFF_0000, 32'hDEAD_BEEF, 2'b00, 0, 0);
    do_txn(1'b0, 16'h0020, 32'hCAFE_F00D, 32'h0F0F_0F0F, 32'h1234_5678, 2'b10, 3, 0);
    // Response back-pressure with a new command waiting.
    do_txn(1'b0, 16'h0030, 32'h0, 32'h0, 32'h8765_4321, 2'b01, 1, 5);
    // Ready on the last allowed cycle, one beyond it, and a long stall.
    do_txn(1'b0, 16'h0040, 32'h0, 32'h0, 32'h1111_2222, 2'b00, TO - 1, 1);
    do_txn(1'b0, 16'h0050, 32'h0, 32'h0, 32'h3333_4444, 2'b01, TO, 0);
    do_txn(1'b1, 16'h0060, 32'h5555_6666, 32'hFFFF_FFFF, 32'h7777_8888, 2'b10, 20, 2);

    // Reset during ACCESS, with ready also high: reset wins.
    i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_address = 16'h0070;
    i_cmd_write_data = 32'h9999_AAAA; i_cmd_write_mask = 32'hFFFF_FFFF;
    step();
    chk("pre_rst_access_valid", 64'(o_access_valid), 64'(1));
    rst = 1'b1; i_access_ready = 1'b1; i_access_status = 2'b01;
    step();
    rst = 1'b0; i_cmd_valid = 1'b0; i_access_ready = 1'b0;
    chk_reset_state("rst_access");
    step();
    chk("post_rst_access_rsp_valid", 64'(o_rsp_valid), 64'(0));
    do_txn(1'b0, 16'h0080, 32'h0, 32'h0, 32'hABCD_EF01, 2'b00, 0, 0);

    // Reset during RESPOND, with response ready also high.
    i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_address = 16'h0090;
    step();
    i_cmd_valid = 1'b0; i_access_ready = 1'b1;
    i_access_read_data = 32'h1357_9BDF; i_access_status = 2'b10;
    step();
    i_access_ready = 1'b0;
    chk("pre_rst_rsp_valid", 64'(o_rsp_valid), 64'(1));
    rst = 1'b1; i_rsp_ready = 1'b1;
    step();
    rst = 1'b0; i_rsp_ready = 1'b0;
    chk_reset_state("rst_respond");
    do_txn(1'b1, 16'h00A0, 32'h2468_ACE0, 32'h00FF_00FF, 32'h0, 2'b00, 2, 1);

    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
             2'($urandom_range(2, 0)), int'($urandom_range(6, 0)), int'($urandom_range(3, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
